// File: rtl/btn_counter_ctrl.sv
// Button front end for the FND counter: synchronize, debounce and edge-detect
// three push-buttons, then drive run/clear/direction controls from a small FSM.
module btn_counter_ctrl #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SAMPLE_HZ = 1_000,
  parameter int DEB_LEN   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  output logic       o_run_en,
  output logic       o_clear,
  output logic       o_up,
  output logic [1:0] o_state
);

  localparam int DIV   = CLK_FREQ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  localparam int B_RUN   = 0;
  localparam int B_CLEAR = 1;
  localparam int B_MODE  = 2;

  logic [CNT_W-1:0] cnt_q;
  logic             sample_tick;
  logic             tick_d1_q;

  assign sample_tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      tick_d1_q <= 1'b0;
    end else begin
      tick_d1_q <= sample_tick;
      if (sample_tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;

  assign btn_raw = {btn_mode, btn_clear, btn_run};

  // One identical sync/debounce/edge chain per button; the level only moves
  // on the clock after a tick, once the whole sample window agrees.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic               sync1_q;
      logic               sync2_q;
      logic [DEB_LEN-1:0] sh_q;
      logic               deb_q;
      logic               deb_d1_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          sh_q     <= '0;
          deb_q    <= 1'b0;
          deb_d1_q <= 1'b0;
        end else begin
          sync1_q  <= btn_raw[gi];
          sync2_q  <= sync1_q;
          deb_d1_q <= deb_q;
          if (sample_tick) begin
            sh_q <= {sh_q[DEB_LEN-2:0], sync2_q};
          end
          if (tick_d1_q) begin
            if (&sh_q) begin
              deb_q <= 1'b1;
            end else if (~|sh_q) begin
              deb_q <= 1'b0;
            end
          end
        end
      end

      assign btn_pulse[gi] = deb_q & ~deb_d1_q;
    end
  endgenerate

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       up_q;
  logic       up_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (btn_pulse[B_CLEAR]) begin
          state_d = ST_CLEAR;
        end else if (btn_pulse[B_RUN]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btn_pulse[B_CLEAR]) begin
          state_d = ST_CLEAR;
        end else if (btn_pulse[B_RUN]) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // Direction is independent of the FSM, so a mode press is honoured even in CLEAR.
  always_comb begin
    up_d = up_q ^ btn_pulse[B_MODE];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
    end
  end

  assign o_run_en = (state_q == ST_RUN);
  assign o_clear  = (state_q == ST_CLEAR);
  assign o_up     = up_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_btn_counter_ctrl.sv
// Bench for btn_counter_ctrl: directed scenarios plus random presses, checked
// every cycle against a sample-window model of the button front end.
module tb_btn_counter_ctrl;
  localparam int CLK_FREQ  = 1000;
  localparam int SAMPLE_HZ = 100;
  localparam int DEB_LEN   = 4;
  localparam int DIV       = CLK_FREQ / SAMPLE_HZ;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_mode = 1'b0;
  logic       o_run_en;
  logic       o_clear;
  logic       o_up;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  btn_counter_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .DEB_LEN  (DEB_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_clear(btn_clear),
    .btn_mode (btn_mode),
    .o_run_en (o_run_en),
    .o_clear  (o_clear),
    .o_up     (o_up),
    .o_state  (o_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: raw history (2-clk sync delay), sample window of DEB_LEN ticks,
  // level/edge, then the control FSM (0 STOP, 1 RUN, 2 CLEAR) and direction.
  bit rawq[3][$];
  bit smp[3][$];
  bit m_lvl[3];
  bit m_lvl1[3];
  int m_st;
  bit m_up;
  int cyc;

  function automatic void model_reset();
    for (int b = 0; b < 3; b++) begin
      rawq[b].delete();
      smp[b].delete();
      for (int k = 0; k < DEB_LEN; k++) smp[b].push_back(1'b0);
      m_lvl[b]  = 1'b0;
      m_lvl1[b] = 1'b0;
    end
    m_st = 0;
    m_up = 1'b1;
    cyc  = 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      bit p[3];
      bit raw[3];
      int ones;
      raw[0] = btn_run;
      raw[1] = btn_clear;
      raw[2] = btn_mode;
      for (int b = 0; b < 3; b++) p[b] = m_lvl[b] && !m_lvl1[b];
      if (m_st == 2) m_st = 0;
      else if (p[1]) m_st = 2;
      else if (p[0]) m_st = (m_st == 0) ? 1 : 0;
      if (p[2]) m_up = !m_up;
      for (int b = 0; b < 3; b++) begin
        m_lvl1[b] = m_lvl[b];
        if (cyc >= 1 && ((cyc - 1) % DIV) == DIV - 1) begin
          ones = 0;
          foreach (smp[b][k]) ones += int'(smp[b][k]);
          if (ones == DEB_LEN) m_lvl[b] = 1'b1;
          else if (ones == 0) m_lvl[b] = 1'b0;
        end
        if ((cyc % DIV) == DIV - 1) begin
          smp[b].push_back(rawq[b].size() >= 2 ? rawq[b][rawq[b].size() - 2] : 1'b0);
          void'(smp[b].pop_front());
        end
        rawq[b].push_back(raw[b]);
        if (rawq[b].size() > 3) void'(rawq[b].pop_front());
      end
      cyc++;
    end
  end

  bit       chk_en = 1'b0;
  logic [1:0] prev_st = 2'b00;
  int st_chg = 0;
  int clr_cyc = 0;
  int clr_st = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(o_state), m_st);
      chk("run_en", int'(o_run_en), int'(m_st == 1));
      chk("clear", int'(o_clear), int'(m_st == 2));
      chk("up", int'(o_up), int'(m_up));
      if (o_state != prev_st) st_chg++;
      prev_st = o_state;
      if (o_clear) begin
        clr_cyc++;
        if (o_state == 2'b10) clr_st++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit [2:0] m, input int hi, input int lo);
    btn_run   = m[0];
    btn_clear = m[1];
    btn_mode  = m[2];
    step(hi);
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_mode  = 1'b0;
    step(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    int c0;
    int cs0;
    model_reset();
    @(posedge clk);
    chk_en = 1'b1;
    step(5);

    // 1: reset state, then first run press
    chk("rst_state", int'(o_state), 0);
    chk("rst_run_en", int'(o_run_en), 0);
    chk("rst_up", int'(o_up), 1);
    chk("rst_clear", int'(o_clear), 0);
    reset = 1'b1;
    step(1);
    btn_run = 1'b1;
    lat = 0;
    while (!o_run_en && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("run_latency_ok", int'(lat <= 45), 1);
    step(100 - lat);
    chk("t1_run_en", int'(o_run_en), 1);
    chk("t1_state", int'(o_state), 1);

    // 2: bounce every 7 clks must never move the level
    s0 = st_chg;
    for (int i = 0; i < 200 / 7; i++) begin
      btn_run = ~btn_run;
      step(7);
    end
    btn_run = 1'b0;
    step(60);
    chk("t2_no_change", st_chg - s0, 0);
    chk("t2_state", int'(o_state), 1);

    // 3: two clean presses then a long hold
    press(3'b001, 60, 60);
    chk("t3_stop", int'(o_state), 0);
    press(3'b001, 60, 60);
    chk("t3_run", int'(o_state), 1);
    s0 = st_chg;
    press(3'b001, 500, 60);
    chk("t3_hold_one", st_chg - s0, 1);
    chk("t3_final", int'(o_state), 0);

    // 4: clear while running
    press(3'b001, 60, 60);
    chk("t4_pre_run", int'(o_state), 1);
    c0 = clr_cyc;
    cs0 = clr_st;
    press(3'b010, 60, 60);
    chk("t4_clr_width", clr_cyc - c0, 1);
    chk("t4_clr_state", clr_st - cs0, 1);
    chk("t4_state", int'(o_state), 0);
    chk("t4_run_en", int'(o_run_en), 0);

    // 5: simultaneous run + clear + mode
    c0 = clr_cyc;
    press(3'b111, 60, 60);
    chk("t5_clr_once", clr_cyc - c0, 1);
    chk("t5_state", int'(o_state), 0);
    chk("t5_up", int'(o_up), 0);

    // random presses, including sub-window glitches
    for (int i = 0; i < 14; i++) begin
      press(3'($urandom_range(7, 0)), $urandom_range(70, 3), $urandom_range(70, 3));
    end
    step(70);

    // 6: reset in the middle of a mode debounce
    btn_mode = 1'b1;
    step(25);
    reset = 1'b0;
    #1;
    chk("t6_up_in_reset", int'(o_up), 1);
    chk("t6_state_in_reset", int'(o_state), 0);
    step(3);
    reset = 1'b1;
    lat = 0;
    while (o_up && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_full_window", int'(lat >= 3 * DIV + 2 && lat <= 2 + DEB_LEN * DIV + 3), 1);
    chk("t6_up", int'(o_up), 0);
    btn_mode = 1'b0;
    step(60);
    chk("t6_up_hold", int'(o_up), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
